bn_stats_seq: RTL and testbench

BN_STATS_SEQ -- requirements
Module: bn_stats_seq

---
 rtl/bn_pkg.sv | 23 ++
 rtl/bn_ch_counter.sv | 30 +++
 rtl/bn_stats_seq.sv | 173 +++++++++++++++++
 tb/tb_bn_stats_seq.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bn_pkg.sv
// Shared definitions for the batch-norm statistics sequencer.
// This package holds the FSM state encoding, the fp16 constants and a small sizing helper.
package bn_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    MEAN  = 3'd2,
    VAR   = 3'd3,
    OUT   = 3'd4
  } bn_state_t;

  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  // The larger of three integers. Used to size the shared cycle counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bn_ch_counter.sv
// Channel index counter for bn_stats_seq.
// It advances once per finished or dropped result and wraps from NUM_CH-1 to 0.
// The last flag is high while the counter points at the final channel of a batch.
module bn_ch_counter #(
  parameter int NUM_CH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      advance,
  output logic [$clog2(NUM_CH)-1:0] ch,
  output logic                      last
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [CH_W-1:0] ch_reg;

  // Channel register: step on advance, wrap after the last channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_reg <= '0;
    end else if (advance) begin
      ch_reg <= (ch_reg == CH_W'(NUM_CH - 1)) ? '0 : ch_reg + 1'b1;
    end
  end

  assign ch   = ch_reg;
  assign last = (ch_reg == CH_W'(NUM_CH - 1));

endmodule

// File: rtl/bn_stats_seq.sv
// bn_stats_seq: sequences one input vector through a shared mean/variance datapath.
// The sequence is accept -> flush datapath -> wait for mean -> wait for variance -> present result.
// Optional feature: define BN_STATS_TIMEOUT_EN to drop a result stalled for TIMEOUT cycles.
// A dropped result sets the sticky err flag.
module bn_stats_seq
  import bn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SIZE       = 4,
  parameter int NUM_CH     = 4,
  parameter int LAT_MEAN   = 2,
  parameter int LAT_VAR    = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH*SIZE-1:0]   in_data,
  output logic [DATA_WIDTH*SIZE-1:0]   dp_x,
  output logic                         dp_rst,
  input  logic [DATA_WIDTH-1:0]        dp_mean,
  input  logic [DATA_WIDTH-1:0]        dp_var,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_mean,
  output logic [DATA_WIDTH-1:0]        out_var,
  output logic [$clog2(NUM_CH)-1:0]    out_ch,
  output logic                         out_last,
  output logic                         busy,
  output logic                         err
);

  localparam int CNT_MAX = max3(LAT_MEAN, LAT_VAR, TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Zero-cycle datapath latencies have no state to count through.
  if (LAT_MEAN < 1) begin : g_bad_lat_mean
    $error("bn_stats_seq: LAT_MEAN must be at least 1");
  end
  if (LAT_VAR < 1) begin : g_bad_lat_var
    $error("bn_stats_seq: LAT_VAR must be at least 1");
  end
  if (NUM_CH < 2) begin : g_bad_num_ch
    $error("bn_stats_seq: NUM_CH must be at least 2");
  end

  bn_state_t                     state_reg, state_next;
  logic [CNT_W-1:0]              cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0]         mean_reg, mean_next;
  logic [DATA_WIDTH-1:0]         var_reg, var_next;
  logic [DATA_WIDTH*SIZE-1:0]    x_reg;
  logic                          accept;
  logic                          ch_advance;

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == OUT);
  // The datapath is also held in flush for as long as reset is asserted.
  assign dp_rst    = (state_reg == FLUSH) | ~reset;
  assign accept    = in_valid & in_ready;
  assign dp_x      = x_reg;
  assign out_mean  = mean_reg;
  assign out_var   = var_reg;

`ifdef BN_STATS_TIMEOUT_EN
  logic err_reg, err_next;
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  // Operand capture: dp_x only changes on an accepted vector, so it is stable until IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_reg <= '0;
    end else if (accept) begin
      x_reg <= in_data;
    end
  end

  // State, shared cycle counter and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mean_reg  <= DATA_WIDTH'(FP16_ZERO);
      var_reg   <= DATA_WIDTH'(FP16_ZERO);
`ifdef BN_STATS_TIMEOUT_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mean_reg  <= mean_next;
      var_reg   <= var_next;
`ifdef BN_STATS_TIMEOUT_EN
      err_reg   <= err_next;
`endif
    end
  end

  // Next-state logic: walk the datapath latencies, then hold the result until it is taken.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mean_next  = mean_reg;
    var_next   = var_reg;
    ch_advance = 1'b0;
`ifdef BN_STATS_TIMEOUT_EN
    err_next   = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        cnt_next   = '0;
        state_next = MEAN;
      end
      MEAN: begin
        if (cnt_reg == CNT_W'(LAT_MEAN - 1)) begin
          mean_next  = dp_mean;
          cnt_next   = '0;
          state_next = VAR;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      VAR: begin
        if (cnt_reg == CNT_W'(LAT_VAR - 1)) begin
          var_next   = dp_var;
          cnt_next   = '0;
          state_next = OUT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          ch_advance = 1'b1;
          state_next = IDLE;
`ifdef BN_STATS_TIMEOUT_EN
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          // Stalled too long: the result is dropped and its channel slot is skipped.
          err_next   = 1'b1;
          ch_advance = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
`endif
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  bn_ch_counter #(
    .NUM_CH (NUM_CH)
  ) u_ch_counter (
    .clk     (clk),
    .reset   (reset),
    .advance (ch_advance),
    .ch      (out_ch),
    .last    (out_last)
  );

endmodule

// File: tb/tb_bn_stats_seq.sv
// Directed self-checking bench for bn_stats_seq with a behavioural mean/variance datapath.
// The datapath model returns a table value once its latency has elapsed after a flush.
// Before that, it returns 16'hFFFF.
// With BN_STATS_TIMEOUT_EN defined, the stall-timeout scenario is also exercised.
module tb_bn_stats_seq;

  localparam int DW = 16;
  localparam int SZ = 4;
  localparam int NC = 4;
  localparam int LM = 2;
  localparam int LV = 2;
  localparam int TO = 8;
`ifdef BN_STATS_TIMEOUT_EN
  localparam int STALL = 5;
`else
  localparam int STALL = 10;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [DW*SZ-1:0] in_data;
  logic [DW*SZ-1:0] dp_x;
  logic            dp_rst;
  logic [DW-1:0]   dp_mean;
  logic [DW-1:0]   dp_var;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_mean;
  logic [DW-1:0]   out_var;
  logic [1:0]      out_ch;
  logic            out_last;
  logic            busy;
  logic            err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW*SZ-1:0] vec [5];
  logic [DW-1:0]    exp_mean [5];
  logic [DW-1:0]    exp_var  [5];

  bn_stats_seq #(
    .DATA_WIDTH (DW),
    .SIZE       (SZ),
    .NUM_CH     (NC),
    .LAT_MEAN   (LM),
    .LAT_VAR    (LV),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dp_x      (dp_x),
    .dp_rst    (dp_rst),
    .dp_mean   (dp_mean),
    .dp_var    (dp_var),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mean  (out_mean),
    .out_var   (out_var),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Datapath model: k counts cycles since the flush cycle.
  int k = 0;
  always @(posedge clk) begin
    if (dp_rst) k <= 1;
    else if (k < 15) k <= k + 1;
  end

  function automatic logic [DW-1:0] lookup_mean(input logic [DW*SZ-1:0] x);
    for (int i = 0; i < 5; i++) if (vec[i] == x) return exp_mean[i];
    return 16'hFFFF;
  endfunction

  function automatic logic [DW-1:0] lookup_var(input logic [DW*SZ-1:0] x);
    for (int i = 0; i < 5; i++) if (vec[i] == x) return exp_var[i];
    return 16'hFFFF;
  endfunction

  always_comb begin
    dp_mean = 16'hFFFF;
    dp_var  = 16'hFFFF;
    if (k >= LM)      dp_mean = lookup_mean(dp_x);
    if (k >= LM + LV) dp_var  = lookup_var(dp_x);
  end

  // Drive one vector at the current negedge.
  // Then wait, bounded, for out_valid; lat counts negedges from the drive.
  task automatic send(input int idx, output int lat, output logic rst_seen, output logic [DW*SZ-1:0] x_seen);
    in_data  = vec[idx];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst_seen = dp_rst;
    x_seen   = dp_x;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (dp_rst !== 1'b1) begin n_fail++; $display("FAIL reset_dp_rst: got %b expected 1", dp_rst); end
    n_checks++; if (dp_x !== 64'h0) begin n_fail++; $display("FAIL reset_dp_x: got %h expected 0", dp_x); end
    n_checks++; if ({out_mean, out_var} !== 32'h0) begin n_fail++; $display("FAIL reset_results: got %h expected 0", {out_mean, out_var}); end
    n_checks++; if ({out_ch, out_last, err} !== 4'h0) begin n_fail++; $display("FAIL reset_ch_last_err: got %b expected 0000", {out_ch, out_last, err}); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (dp_rst !== 1'b0) begin n_fail++; $display("FAIL idle_dp_rst: got %b expected 0", dp_rst); end
  endtask

  task automatic test_basic();
    int lat;
    logic rs;
    logic [DW*SZ-1:0] xs;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b expected 1", in_ready); end
    send(0, lat, rs, xs);
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL basic_latency: got %0d expected 6", lat); end
    n_checks++; if (rs !== 1'b1) begin n_fail++; $display("FAIL basic_flush: got %b expected 1", rs); end
    n_checks++; if (xs !== 64'h4400_4200_4000_3C00) begin n_fail++; $display("FAIL basic_dp_x: got %h expected 4400420040003c00", xs); end
    n_checks++; if (out_mean !== 16'h4100) begin n_fail++; $display("FAIL basic_mean: got %h expected 4100", out_mean); end
    n_checks++; if (out_var !== 16'h3D00) begin n_fail++; $display("FAIL basic_var: got %h expected 3d00", out_var); end
    n_checks++; if ({out_ch, out_last} !== 3'b000) begin n_fail++; $display("FAIL basic_ch_last: got %b expected 000", {out_ch, out_last}); end
    n_checks++; if ({in_ready, busy, dp_rst, err} !== 4'b0100) begin n_fail++; $display("FAIL basic_out_flags: got %b expected 0100", {in_ready, busy, dp_rst, err}); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if ({out_valid, in_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL basic_release: got %b expected 010", {out_valid, in_ready, busy}); end
  endtask

  task automatic test_ignore();
    int lat;
    int bad;
    in_data  = vec[2];
    in_valid = 1'b1;
    @(negedge clk);
    in_data = vec[3];
    lat = 1;
    bad = 0;
    if (dp_x !== vec[2]) bad++;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (dp_x !== vec[2]) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ignore_dp_x_hold: got %0d bad cycles expected 0", bad); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 6", lat); end
    n_checks++; if ({out_mean, out_var} !== {exp_mean[2], exp_var[2]}) begin n_fail++; $display("FAIL ignore_result1: got %h expected %h", {out_mean, out_var}, {exp_mean[2], exp_var[2]}); end
    n_checks++; if (out_ch !== 2'd1) begin n_fail++; $display("FAIL ignore_ch1: got %0d expected 1", out_ch); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if ({in_ready, out_valid} !== 2'b10 || dp_x !== vec[2]) begin n_fail++; $display("FAIL ignore_release_no_capture: got %b/%h expected 10/%h", {in_ready, out_valid}, dp_x, vec[2]); end
    // in_valid is still high, so vec[3] is accepted at the next edge.
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (lat !== 6 || dp_x !== vec[3]) begin n_fail++; $display("FAIL ignore_second: got lat %0d x %h expected 6 x %h", lat, dp_x, vec[3]); end
    n_checks++; if ({out_mean, out_var, out_ch} !== {exp_mean[3], exp_var[3], 2'd2}) begin n_fail++; $display("FAIL ignore_result2: got %h/%h/%0d expected %h/%h/2", out_mean, out_var, out_ch, exp_mean[3], exp_var[3]); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int lat;
    int bad;
    logic rs;
    logic [DW*SZ-1:0] xs;
    send(4, lat, rs, xs);
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL stall_latency: got %0d expected 6", lat); end
    n_checks++; if ({out_ch, out_last} !== 3'b111) begin n_fail++; $display("FAIL stall_last_ch: got %b expected 111", {out_ch, out_last}); end
    bad = 0;
    in_data  = vec[0];
    in_valid = 1'b1;
    for (int c = 0; c < STALL; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_mean !== 16'h4000 || out_var !== 16'h3C00 ||
          out_ch !== 2'd3 || out_last !== 1'b1 || dp_x !== vec[4]) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL stall_release: got %b expected 01", {out_valid, in_ready}); end
    n_checks++; if ({out_ch, out_last} !== 3'b000) begin n_fail++; $display("FAIL stall_wrap: got %b expected 000", {out_ch, out_last}); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic rs;
    logic [DW*SZ-1:0] xs;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, in_ready); end
      send(i, lat, rs, xs);
      n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL b2b_latency_%0d: got %0d expected 6", i, lat); end
      n_checks++; if (out_ch !== 2'(i % 4) || out_last !== (i % 4 == 3)) begin n_fail++; $display("FAIL b2b_ch_%0d: got ch %0d last %b expected ch %0d last %b", i, out_ch, out_last, i % 4, i % 4 == 3); end
      n_checks++; if ({out_mean, out_var} !== {exp_mean[i], exp_var[i]}) begin n_fail++; $display("FAIL b2b_result_%0d: got %h expected %h", i, {out_mean, out_var}, {exp_mean[i], exp_var[i]}); end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic rs;
    logic [DW*SZ-1:0] xs;
    in_data  = vec[1];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b1 || out_mean !== 16'h4000) begin n_fail++; $display("FAIL mid_pre: got busy %b mean %h expected 1 4000", busy, out_mean); end
    reset = 1'b0;
    #1;
    n_checks++; if ({busy, out_valid, in_ready, dp_rst} !== 4'b0011) begin n_fail++; $display("FAIL mid_async: got %b expected 0011", {busy, out_valid, in_ready, dp_rst}); end
    n_checks++; if (dp_x !== 64'h0 || {out_mean, out_var} !== 32'h0 || out_ch !== 2'd0) begin n_fail++; $display("FAIL mid_clear: got %h/%h/%0d expected 0/0/0", dp_x, {out_mean, out_var}, out_ch); end
    @(negedge clk);
    n_checks++; if ({busy, out_valid} !== 2'b00) begin n_fail++; $display("FAIL mid_next_cycle: got %b expected 00", {busy, out_valid}); end
    reset = 1'b1;
    @(negedge clk);
    send(0, lat, rs, xs);
    n_checks++; if (lat !== 6 || out_ch !== 2'd0) begin n_fail++; $display("FAIL mid_after: got lat %0d ch %0d expected 6 0", lat, out_ch); end
    n_checks++; if ({out_mean, out_var} !== 32'h4100_3D00) begin n_fail++; $display("FAIL mid_after_result: got %h expected 41003d00", {out_mean, out_var}); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %b expected 0", err); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

`ifdef BN_STATS_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    int bad;
    logic rs;
    logic [DW*SZ-1:0] xs;
    do_reset();
    send(1, lat, rs, xs);
    n_checks++; if (lat !== 6 || out_ch !== 2'd0) begin n_fail++; $display("FAIL to_first: got lat %0d ch %0d expected 6 0", lat, out_ch); end
    bad = 0;
    for (int c = 0; c < TO - 1; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || err !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL to_before_limit: got %0d bad cycles expected 0", bad); end
    @(negedge clk);
    n_checks++; if ({err, busy, in_ready, out_valid} !== 4'b1010) begin n_fail++; $display("FAIL to_drop: got %b expected 1010", {err, busy, in_ready, out_valid}); end
    out_ready = 1'b1;
    send(2, lat, rs, xs);
    n_checks++; if (lat !== 6 || out_ch !== 2'd1) begin n_fail++; $display("FAIL to_next_ch: got lat %0d ch %0d expected 6 1", lat, out_ch); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", err); end
    @(negedge clk);
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    vec[0] = 64'h4400_4200_4000_3C00; exp_mean[0] = 16'h4100; exp_var[0] = 16'h3D00;
    vec[1] = 64'h4000_4000_4000_4000; exp_mean[1] = 16'h4000; exp_var[1] = 16'h0000;
    vec[2] = 64'h3C00_3C00_3C00_3C00; exp_mean[2] = 16'h3C00; exp_var[2] = 16'h0000;
    vec[3] = 64'h4400_4400_0000_0000; exp_mean[3] = 16'h4000; exp_var[3] = 16'h4400;
    vec[4] = 64'h4200_3C00_4200_3C00; exp_mean[4] = 16'h4000; exp_var[4] = 16'h3C00;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_ignore();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef BN_STATS_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
